// File: rtl/conv_layer_multi.sv
// conv_layer_multi: NUM_KERNELS parallel valid-mode 1-D convolutions down the height axis of a
// row-major input matrix, with runtime-loadable kernels/biases, saturation and optional ReLU.
module conv_layer_multi #(
    parameter int INPUT_LAYER_HEIGHT = 4,
    parameter int KERNEL_HEIGHT      = 3,
    parameter int KERNEL_WIDTH       = 2,
    parameter int NUM_KERNELS        = 2,
    parameter int WORD_SIZE          = 8,
    parameter int INT_BITS           = 8,
    parameter bit RELU_EN            = 1'b0
) (
    input  logic                                                                  clk_i,
    input  logic                                                                  reset_i,
    input  logic                                                                  start_i,
    input  logic                                                                  valid_i,
    output logic                                                                  ready_o,
    input  logic [WORD_SIZE-1:0]                                                  data_i,
    input  logic                                                                  w_wen_i,
    input  logic [$clog2(NUM_KERNELS*(KERNEL_HEIGHT*KERNEL_WIDTH+1))-1:0]         w_addr_i,
    input  logic [WORD_SIZE-1:0]                                                  w_data_i,
    output logic                                                                  valid_o,
    input  logic                                                                  yumi_i,
    output logic [NUM_KERNELS-1:0][INPUT_LAYER_HEIGHT-KERNEL_HEIGHT:0][WORD_SIZE-1:0] data_o
);
    localparam int FRAC       = WORD_SIZE - INT_BITS;
    localparam int OUT_HEIGHT = INPUT_LAYER_HEIGHT - KERNEL_HEIGHT + 1;
    localparam int TAPS       = KERNEL_HEIGHT * KERNEL_WIDTH;
    localparam int N_IN       = INPUT_LAYER_HEIGHT * KERNEL_WIDTH;
    localparam int N_W        = NUM_KERNELS * (TAPS + 1);
    localparam int XA         = N_IN > 1 ? $clog2(N_IN) : 1;
    localparam int WA         = $clog2(N_W);
    localparam int TA         = TAPS > 1 ? $clog2(TAPS) : 1;
    localparam int JA         = OUT_HEIGHT > 1 ? $clog2(OUT_HEIGHT) : 1;
    localparam int AW         = 2 * WORD_SIZE + $clog2(TAPS + 1);
    localparam logic signed [AW-1:0] SMAX = AW'((1 << (WORD_SIZE - 1)) - 1);
    localparam logic signed [AW-1:0] SMIN = -SMAX - 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DONE} state_t;

    state_t                       r_state, w_state_nx;
    logic [WORD_SIZE-1:0]         r_w [N_W];
    logic [WORD_SIZE-1:0]         r_x [N_IN];
    logic signed [AW-1:0]         r_acc [NUM_KERNELS];
    logic [XA-1:0]                r_idx;
    logic [TA-1:0]                r_t;
    logic [JA-1:0]                r_j;
    logic                         w_accept, w_last_in, w_last_tap, w_last_j;
    logic [XA-1:0]                w_xi;
    logic signed [2*WORD_SIZE-1:0] w_prod [NUM_KERNELS];
    logic signed [AW-1:0]         w_bias [NUM_KERNELS];
    logic signed [AW-1:0]         w_acc_nx [NUM_KERNELS];
    logic signed [AW-1:0]         w_sh [NUM_KERNELS];
    logic signed [AW-1:0]         w_sat [NUM_KERNELS];
    logic [WORD_SIZE-1:0]         w_res [NUM_KERNELS];

    assign w_accept   = (r_state == S_LOAD) && valid_i;
    assign w_last_in  = r_idx == XA'(N_IN - 1);
    assign w_last_tap = r_t == TA'(TAPS - 1);
    assign w_last_j   = r_j == JA'(OUT_HEIGHT - 1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= S_IDLE;
        else         r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        ready_o    = r_state == S_LOAD;
        valid_o    = r_state == S_DONE;
        case (r_state)
            S_IDLE:    if (start_i) w_state_nx = S_LOAD;
            S_LOAD:    if (w_accept && w_last_in) w_state_nx = S_COMPUTE;
            S_COMPUTE: if (w_last_tap && w_last_j) w_state_nx = S_DONE;
            S_DONE:    if (yumi_i) w_state_nx = S_IDLE;
            default:   w_state_nx = S_IDLE;
        endcase
    end

    // Tap t of output j reads x[j+i][c], which in row-major order is simply j*KERNEL_WIDTH + t.
    always_comb begin
        w_xi = XA'(int'(r_j) * KERNEL_WIDTH + int'(r_t));
        for (int k = 0; k < NUM_KERNELS; k++) begin
            w_bias[k]   = AW'($signed(r_w[WA'(k * (TAPS + 1) + TAPS)])) <<< FRAC;
            w_prod[k]   = (2*WORD_SIZE)'($signed(r_w[WA'(k * (TAPS + 1) + int'(r_t))]))
                        * (2*WORD_SIZE)'($signed(r_x[w_xi]));
            w_acc_nx[k] = (r_t == '0 ? w_bias[k] : r_acc[k]) + AW'(w_prod[k]);
            w_sh[k]     = w_acc_nx[k] >>> FRAC;
            w_sat[k]    = w_sh[k] > SMAX ? SMAX : w_sh[k] < SMIN ? SMIN : w_sh[k];
            w_res[k]    = (RELU_EN && w_sat[k][AW-1]) ? '0 : w_sat[k][WORD_SIZE-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_w    <= '{default: '0};
            r_x    <= '{default: '0};
            r_acc  <= '{default: '0};
            r_idx  <= '0;
            r_t    <= '0;
            r_j    <= '0;
            data_o <= '0;
        end else begin
            if (r_state == S_IDLE && w_wen_i && int'(w_addr_i) < N_W)
                r_w[w_addr_i] <= w_data_i;
            if (w_accept) begin
                r_x[r_idx] <= data_i;
                r_idx      <= w_last_in ? '0 : r_idx + 1'b1;
            end
            if (r_state == S_COMPUTE) begin
                r_acc <= w_acc_nx;
                r_t   <= w_last_tap ? '0 : r_t + 1'b1;
                if (w_last_tap) r_j <= w_last_j ? '0 : r_j + 1'b1;
                for (int k = 0; k < NUM_KERNELS; k++)
                    if (w_last_tap) data_o[k][r_j] <= w_res[k];
            end
        end
    end
endmodule

// File: tb/tb_conv_layer_multi.sv
// tb_conv_layer_multi: directed and randomized checks of conv_layer_multi (plain and ReLU builds)
// against an arithmetic reference model of the convolution.
module tb_conv_layer_multi;
    localparam int FRAC = 0;

    logic clk_i = 1'b0;
    logic reset_i, start_i, valid_i, w_wen_i, yumi_i;
    logic [7:0] data_i, w_data_i;
    logic [3:0] w_addr_i;
    logic ready_o, valid_o, ready_r, valid_r;
    logic [1:0][1:0][7:0] data_o, data_r;

    logic [7:0] wm [14];
    logic [7:0] xm [8];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    conv_layer_multi u_dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .w_wen_i(w_wen_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
        .valid_o(valid_o), .yumi_i(yumi_i), .data_o(data_o)
    );

    conv_layer_multi #(.RELU_EN(1'b1)) u_relu (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .valid_i(valid_i), .ready_o(ready_r),
        .data_i(data_i), .w_wen_i(w_wen_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
        .valid_o(valid_r), .yumi_i(yumi_i), .data_o(data_r)
    );

    function automatic logic [7:0] ref_y(int k, int j, bit relu);
        int acc;
        acc = int'(byte'(wm[k*7+6])) <<< FRAC;
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < 2; c++)
                acc += int'(byte'(wm[k*7+i*2+c])) * int'(byte'(xm[(j+i)*2+c]));
        acc = acc >>> FRAC;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        if (relu && acc < 0) acc = 0;
        return 8'(acc);
    endfunction

    function automatic logic [31:0] ref_vec(bit relu);
        logic [1:0][1:0][7:0] v;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 2; j++)
                v[k][j] = ref_y(k, j, relu);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        w_wen_i = 1'b1; w_addr_i = 4'(a); w_data_i = d;
        @(posedge clk_i); #1;
        w_wen_i = 1'b0;
        if (a < 14) wm[a] = d;
    endtask

    task automatic set_default();
        logic [7:0] k0 [7];
        k0 = '{8'd1, 8'd6, 8'd1, 8'd5, 8'd2, 8'd3, 8'h0f};
        for (int t = 0; t < 7; t++) wr(t, k0[t]);
        for (int t = 7; t < 13; t++) wr(t, 8'h01);
        wr(13, 8'h00);
    endtask

    task automatic set_x(input logic [63:0] v);
        for (int i = 0; i < 8; i++) xm[i] = v[63-8*i -: 8];
    endtask

    // One full transaction: start (optionally with a simultaneous weight write), load, compute, hold, yumi.
    task automatic run(input string tag, input bit gaps, input int ydly, input bit junk,
                       input bit sw, input int sw_a, input logic [7:0] sw_d);
        logic [31:0] en, er;
        int idx, cyc, guard;
        bit hs, rdy_bad;
        if (sw) begin
            w_wen_i = 1'b1; w_addr_i = 4'(sw_a); w_data_i = sw_d;
            wm[sw_a] = sw_d;
        end
        en = ref_vec(1'b0);
        er = ref_vec(1'b1);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; w_wen_i = 1'b0;
        chk({tag, " ready_in_load"}, 32'(ready_o), 32'd1);
        idx = 0; guard = 0;
        while (idx < 8 && guard < 200) begin
            valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            data_i  = valid_i ? xm[idx] : 8'($urandom);
            if (junk) begin w_wen_i = 1'b1; w_addr_i = 4'd0; w_data_i = 8'h55; end
            hs = valid_i && ready_o;
            @(posedge clk_i); #1;
            if (hs) idx++;
            guard++;
        end
        valid_i = 1'b0;
        chk({tag, " words_loaded"}, 32'(idx), 32'd8);
        cyc = 0; rdy_bad = 1'b0;
        while (!valid_o && cyc < 40) begin
            valid_i = 1'($urandom_range(0, 1));
            rdy_bad |= ready_o | ready_r;
            @(posedge clk_i); #1;
            cyc++;
        end
        valid_i = 1'b0; w_wen_i = 1'b0;
        chk({tag, " latency"}, 32'(cyc), 32'd12);
        chk({tag, " ready_low_compute"}, 32'(rdy_bad), 32'd0);
        for (int d = 0; d < ydly; d++) begin
            chk({tag, " hold_data"}, data_o, en);
            chk({tag, " hold_valid"}, 32'(valid_o), 32'd1);
            chk({tag, " hold_ready"}, 32'(ready_o), 32'd0);
            @(posedge clk_i); #1;
        end
        chk({tag, " data"}, data_o, en);
        chk({tag, " relu_data"}, data_r, er);
        chk({tag, " relu_valid"}, 32'(valid_r), 32'd1);
        yumi_i = 1'b1;
        @(posedge clk_i); #1;
        yumi_i = 1'b0;
        chk({tag, " valid_after_yumi"}, 32'(valid_o), 32'd0);
        chk({tag, " data_after_yumi"}, data_o, en);
    endtask

    initial begin
        int idx;
        reset_i = 1'b1; start_i = 1'b0; valid_i = 1'b0; w_wen_i = 1'b0; yumi_i = 1'b0;
        data_i = '0; w_data_i = '0; w_addr_i = '0;
        for (int i = 0; i < 14; i++) wm[i] = '0;
        #12;
        chk("reset ready", 32'(ready_o), 32'd0);
        chk("reset valid", 32'(valid_o), 32'd0);
        chk("reset data", data_o, 32'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;

        // valid_i and yumi_i in IDLE must not start anything
        valid_i = 1'b1; yumi_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0; yumi_i = 1'b0;
        chk("idle ignores valid", 32'(ready_o | valid_o), 32'd0);

        set_default();
        wr(14, 8'h77);
        wr(15, 8'h66);
        set_x(64'h01_05_03_02_09_05_00_01);
        run("t1", 1'b0, 0, 1'b0, 1'b0, 0, 8'h00);
        chk("t1 const", data_o, 32'h1419_435c);

        set_x(64'h03_01_01_02_0f_0f_05_06);
        run("t2", 1'b0, 0, 1'b0, 1'b0, 0, 8'h00);
        chk("t2 k0 saturate", 32'(data_o[0]), 32'h7f6e);

        for (int t = 7; t < 13; t++) wr(t, 8'hff);
        for (int i = 0; i < 8; i++) xm[i] = 8'h7f;
        run("t3", 1'b0, 0, 1'b0, 1'b0, 0, 8'h00);
        chk("t3 k1 neg sat", 32'(data_o[1]), 32'h8080);
        chk("t3 k1 relu", 32'(data_r[1]), 32'h0000);

        for (int r = 0; r < 4; r++) begin
            for (int t = 0; t < 14; t++) wr(t, 8'($urandom));
            for (int i = 0; i < 8; i++) xm[i] = 8'($urandom);
            run("t4 random", 1'b1, 5, 1'b0, 1'b0, 0, 8'h00);
        end

        set_default();
        set_x(64'h01_05_03_02_09_05_00_01);
        run("t5 junk writes", 1'b1, 2, 1'b1, 1'b0, 0, 8'h00);
        chk("t5 const", data_o, 32'h1419_435c);
        run("t5 start+write", 1'b0, 0, 1'b0, 1'b1, 13, 8'h10);
        chk("t5 new bias", 32'(data_o[1]), 32'h2429);

        // reset in the middle of COMPUTE
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        idx = 0;
        while (idx < 8) begin
            valid_i = 1'b1; data_i = xm[idx];
            @(posedge clk_i); #1;
            idx++;
        end
        valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #2;
        reset_i = 1'b1;
        #1;
        chk("t6 async valid", 32'(valid_o), 32'd0);
        chk("t6 async ready", 32'(ready_o), 32'd0);
        chk("t6 async data", data_o, 32'd0);
        chk("t6 async relu data", data_r, 32'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        for (int i = 0; i < 14; i++) wm[i] = '0;
        run("t6 cleared weights", 1'b0, 0, 1'b0, 1'b0, 0, 8'h00);
        chk("t6 zero result", data_o, 32'd0);
        set_default();
        run("t6 rerun", 1'b0, 0, 1'b0, 1'b0, 0, 8'h00);
        chk("t6 const", data_o, 32'h1419_435c);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
